result_demux6: RTL and testbench



---
 rtl/result_route_pkg.sv | 20 ++
 rtl/demux_slot.sv | 30 +++
 rtl/result_demux6.sv | 71 +++++++
 tb/tb_result_demux6.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/result_route_pkg.sv
// rtl/result_route_pkg.sv - shared routing constants and destination-code helpers
package result_route_pkg;

    localparam int WIDTH   = 64;
    localparam int NUM_OUT = 6;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 16;

    localparam logic [SEL_W-1:0] DST_0 = 3'd0;
    localparam logic [SEL_W-1:0] DST_1 = 3'd1;
    localparam logic [SEL_W-1:0] DST_2 = 3'd2;
    localparam logic [SEL_W-1:0] DST_3 = 3'd3;
    localparam logic [SEL_W-1:0] DST_4 = 3'd4;
    localparam logic [SEL_W-1:0] DST_5 = 3'd5;

    function automatic logic is_legal_sel(input logic [SEL_W-1:0] sel);
        return int'(sel) < NUM_OUT;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output holding register with load/drain/hold
module demux_slot #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free
);

    // A draining slot can be refilled in the same cycle.
    assign free = !valid || ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/result_demux6.sv
// rtl/result_demux6.sv - steers one result stream to six registered consumer channels
module result_demux6
    import result_route_pkg::*;
#(
    parameter int WIDTH   = result_route_pkg::WIDTH,
    parameter int NUM_OUT = result_route_pkg::NUM_OUT,
    parameter int SEL_W   = result_route_pkg::SEL_W,
    parameter int CNT_W   = result_route_pkg::CNT_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    input  logic [SEL_W-1:0]                in_sel,
    output logic [NUM_OUT-1:0]              out_valid,
    input  logic [NUM_OUT-1:0]              out_ready,
    output logic [NUM_OUT-1:0][WIDTH-1:0]   out_data,
    output logic [CNT_W-1:0]                drop_count,
    output logic                            drop_err
);

    logic [NUM_OUT-1:0] free;
    logic [NUM_OUT-1:0] load;
    logic               drop;
    logic [CNT_W-1:0]   drop_cnt;
    logic               drop_flag;

    // Illegal codes leave in_ready at 1 so the producer never stalls on them.
    always_comb begin
        in_ready = 1'b1;
        load     = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (in_sel == SEL_W'(k)) begin
                in_ready = free[k];
                load[k]  = in_valid && free[k];
            end
        end
    end

    assign drop = in_valid && !is_legal_sel(in_sel);

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[g]),
            .load_data (in_data),
            .ready     (out_ready[g]),
            .valid     (out_valid[g]),
            .data      (out_data[g]),
            .free      (free[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt  <= '0;
            drop_flag <= 1'b0;
        end else if (drop) begin
            if (drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            drop_flag <= 1'b1;
        end
    end

    assign drop_count = drop_cnt;
    assign drop_err   = drop_flag;

endmodule

// File: tb/tb_result_demux6.sv
// tb/tb_result_demux6.sv - scoreboard bench for result_demux6
module tb_result_demux6;
    import result_route_pkg::*;

    localparam int N = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_data;
    logic [2:0]        in_sel;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready;
    logic [N-1:0][63:0] out_data;
    logic [15:0]       drop_count;
    logic              drop_err;

    typedef struct {
        int          ch;
        logic [63:0] d;
    } ent_t;

    ent_t        sbq[$];
    logic [15:0] m_cnt;
    logic        m_err;
    int          compared   = 0;
    int          mismatched = 0;
    int          accepted;
    int          budget;

    always #5 clk = ~clk;

    result_demux6 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_count (drop_count),
        .drop_err   (drop_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int find(input int k);
        foreach (sbq[i]) if (sbq[i].ch == k) return i;
        return -1;
    endfunction

    // Compare DUT against the model at the negedge, then advance the model across the posedge.
    task automatic step();
        logic [N-1:0] ev;
        logic         er;
        int           idx;
        @(negedge clk);
        for (int k = 0; k < N; k++) ev[k] = (find(k) >= 0);
        check("out_valid", 64'(out_valid), 64'(ev));
        for (int k = 0; k < N; k++)
            if (ev[k]) check($sformatf("out_data%0d", k), out_data[k], sbq[find(k)].d);
        er = 1'b1;
        if (int'(in_sel) < N) er = !ev[in_sel] || out_ready[in_sel];
        check("in_ready", 64'(in_ready), 64'(er));
        check("drop_count", 64'(drop_count), 64'(m_cnt));
        check("drop_err", 64'(drop_err), 64'(m_err));
        if (rst) begin
            sbq.delete();
            m_cnt = '0;
            m_err = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (ev[k] && out_ready[k]) begin
                    idx = find(k);
                    sbq.delete(idx);
                end
            end
            if (in_valid && er) begin
                if (int'(in_sel) < N) begin
                    sbq.push_back('{ch: int'(in_sel), d: in_data});
                    accepted++;
                end else begin
                    if (m_cnt != 16'hFFFF) m_cnt++;
                    m_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '1;
        accepted  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        m_cnt = '0;
        m_err = 1'b0;

        check("reset_out_valid", 64'(out_valid), 64'd0);
        compared++;
        assert (out_data === '0) else begin
            mismatched++;
            $error("FAIL reset_out_data observed=%0h expected=0", out_data);
        end
        check("reset_drop_count", 64'(drop_count), 64'd0);
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #1;
            check($sformatf("idle_in_ready_sel%0d", s), 64'(in_ready), 64'd1);
        end
        step();

        // Routing to channel 3
        in_valid = 1'b1;
        in_sel   = DST_3;
        in_data  = 64'hDEAD_BEEF_0000_0003;
        step();
        in_valid = 1'b0;
        check("route_valid", 64'(out_valid), 64'b001000);
        check("route_data", out_data[3], 64'hDEAD_BEEF_0000_0003);
        step();
        step();
        check("route_cleared", 64'(out_valid), 64'd0);

        // Backpressure on channel 2
        out_ready = 6'b111011;
        in_valid  = 1'b1;
        in_sel    = DST_2;
        in_data   = 64'h2222_0000_0000_000A;
        step();
        in_data = 64'h2222_0000_0000_000B;
        #1;
        check("bp_ready_ch2", 64'(in_ready), 64'd0);
        in_sel = DST_4;
        #1;
        check("bp_ready_ch4", 64'(in_ready), 64'd1);
        in_sel = DST_2;
        step();
        check("bp_held", out_data[2], 64'h2222_0000_0000_000A);
        out_ready = '1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("bp_second", out_data[2], 64'h2222_0000_0000_000B);
        step();
        step();
        check("bp_drained", 64'(sbq.size()), 64'd0);

        // Random legal traffic with random backpressure
        accepted = 0;
        budget   = 0;
        while (accepted < 100 && budget < 2000) begin
            in_valid  = 1'b1;
            in_sel    = 3'($urandom_range(0, N - 1));
            in_data   = {$urandom, $urandom};
            out_ready = 6'($urandom);
            step();
            budget++;
        end
        check("rand_accepted", 64'(accepted), 64'd100);
        in_valid  = 1'b0;
        out_ready = '1;
        repeat (3) step();
        check("rand_drained", 64'(sbq.size()), 64'd0);

        // Illegal destination codes
        in_valid = 1'b1;
        in_sel   = 3'd6;
        #1;
        check("illegal6_ready", 64'(in_ready), 64'd1);
        step();
        in_sel = 3'd7;
        step();
        in_valid = 1'b0;
        check("drop_count_2", 64'(drop_count), 64'd2);
        check("drop_err_set", 64'(drop_err), 64'd1);
        check("illegal_no_valid", 64'(out_valid), 64'd0);
        step();

        force dut.drop_cnt = 16'hFFFF;
        #1;
        release dut.drop_cnt;
        m_cnt    = 16'hFFFF;
        in_valid = 1'b1;
        in_sel   = 3'd7;
        step();
        step();
        in_valid = 1'b0;
        check("drop_saturated", 64'(drop_count), 64'hFFFF);
        step();

        // Reset while channels 1 and 5 are full and stalled
        out_ready = '0;
        in_valid  = 1'b1;
        in_sel    = DST_1;
        in_data   = 64'h1111_1111_1111_1111;
        step();
        in_sel  = DST_5;
        in_data = 64'h5555_5555_5555_5555;
        step();
        check("pre_reset_valid", 64'(out_valid), 64'b100010);
        in_sel  = DST_0;
        in_data = 64'h0000_0000_0000_00FF;
        rst     = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("post_reset_valid", 64'(out_valid), 64'd0);
        check("post_reset_count", 64'(drop_count), 64'd0);
        check("post_reset_err", 64'(drop_err), 64'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
